// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/sub: one CHUNK-bit slice per stage, latency NSTAGE cycles.
// Global stall: the whole pipe holds while a result waits (o_valid & ~i_ready); o_ready = advance.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);
  localparam int NSTAGE = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $fatal(1, "pipelined_adder: WIDTH must be an integer multiple of CHUNK");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             v_q [NSTAGE];
  logic             c_q [NSTAGE];
  logic             m_q [NSTAGE];
  logic [WIDTH-1:0] a_q [NSTAGE];
  logic [WIDTH-1:0] b_q [NSTAGE];
  logic [WIDTH-1:0] s_q [NSTAGE];

  logic [WIDTH-1:0] op_a  [NSTAGE];
  logic [WIDTH-1:0] op_b  [NSTAGE];
  logic             op_c  [NSTAGE];
  logic [WIDTH-1:0] s_nxt [NSTAGE];

  logic [WIDTH-1:0]  slice_sum;
  logic [NSTAGE-1:0] slice_co;
  logic [NSTAGE-1:0] slice_cm;

  assign advance = ~o_valid | i_ready;
  assign o_ready = advance;
  assign b_eff   = i_sub ? ~i_b : i_b;
  assign cin_eff = i_sub | i_cin;

  // Stage k works on operands/partial sum held by stage k-1 (stage 0 on the ports).
  always_comb begin
    op_a[0]  = i_a;
    op_b[0]  = b_eff;
    op_c[0]  = cin_eff;
    s_nxt[0] = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      op_a[k]  = a_q[k-1];
      op_b[k]  = b_q[k-1];
      op_c[k]  = c_q[k-1];
      s_nxt[k] = s_q[k-1];
    end
    for (int k = 0; k < NSTAGE; k++) begin
      s_nxt[k][k*CHUNK +: CHUNK] = slice_sum[k*CHUNK +: CHUNK];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    for (genvar j = 0; j < CHUNK; j++) begin : g_bit
      logic ci;
      logic co;
      if (j == 0) begin : g_first
        assign ci = op_c[k];
      end else begin : g_chain
        assign ci = g_bit[j-1].co;
      end
      full_adder u_fa (
        .a  (op_a[k][k*CHUNK+j]),
        .b  (op_b[k][k*CHUNK+j]),
        .ci (ci),
        .s  (slice_sum[k*CHUNK+j]),
        .co (co)
      );
    end
    assign slice_co[k] = g_bit[CHUNK-1].co;
    assign slice_cm[k] = g_bit[CHUNK-1].ci;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q[0] <= i_valid;
      for (int k = 1; k < NSTAGE; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= op_a[k];
        b_q[k] <= op_b[k];
        c_q[k] <= slice_co[k];
        m_q[k] <= slice_cm[k];
        s_q[k] <= s_nxt[k];
      end
    end
  end

  assign o_valid = v_q[NSTAGE-1];
  assign o_sum   = s_q[NSTAGE-1];
  assign o_cout  = c_q[NSTAGE-1];
  assign o_ovf   = m_q[NSTAGE-1] ^ c_q[NSTAGE-1];
  // Qualified with valid so the flag reads 0 out of reset.
  assign o_zero  = o_valid & ~|o_sum;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder (WIDTH=32, CHUNK=8, latency 4).
module tb_pipelined_adder;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_cin;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sum;
  logic        o_cout;
  logic        o_ovf;
  logic        o_zero;

  int n_chk = 0;
  int n_bad = 0;
  int sent, got, stall, cyc, ghost;

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf),
    .o_zero  (o_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez);
    int lat;
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_sub   = sub;
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(o_sum), 64'(es));
    chk({tag, "_cout"}, 64'(o_cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(o_ovf), 64'(eo));
    chk({tag, "_zero"}, 64'(o_zero), 64'(ez));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_cin   = 1'b0;
    i_sub   = 1'b0;
    i_ready = 1'b1;
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_sum", 64'(o_sum), 64'd0);
    chk("rst_cout", 64'(o_cout), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    chk("rst_zero", 64'(o_zero), 64'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step();
    chk("rel_ready", 64'(o_ready), 64'd1);

    run_op("add_slice", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("add_cin",   32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("sub_neg",   32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_pos",   32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: 6 ops, result port stalled 3 cycles once the first result shows.
    sent = 0; got = 0; stall = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      i_valid = (sent < 6);
      i_a     = 32'(sent + 1);
      i_b     = 32'h10;
      i_cin   = 1'b0;
      i_sub   = 1'b0;
      if (o_valid && got == 0 && stall == 0 && cyc < 8) stall = 3;
      i_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("bp_ready", 64'(o_ready), 64'd0);
        chk("bp_hold", 64'(o_sum), 64'h11);
        chk("bp_vld_hold", 64'(o_valid), 64'd1);
      end else if (got > 0) begin
        chk("bp_gap", 64'(o_valid), 64'd1);
      end
      if (o_valid && i_ready) begin
        chk("bp_sum", 64'(o_sum), 64'(32'h11 + got));
        got++;
      end
      if (i_valid && o_ready) sent++;
      if (stall > 0) stall--;
      cyc++;
      step();
    end
    chk("bp_count", 64'(got), 64'd6);
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();

    // Full throughput: one op per cycle, result stream must be gap-free.
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 40) begin
      i_valid = (sent < 8);
      i_a     = 32'(32'h100 + sent + 1);
      i_b     = 32'hFFFFFF00;
      i_ready = 1'b1;
      #1;
      chk("tp_ready", 64'(o_ready), 64'd1);
      if (got > 0) chk("tp_gap", 64'(o_valid), 64'd1);
      if (o_valid) begin
        chk("tp_sum", 64'(o_sum), 64'(got + 1));
        chk("tp_cout", 64'(o_cout), 64'd1);
        got++;
      end
      if (i_valid && o_ready) sent++;
      cyc++;
      step();
    end
    chk("tp_count", 64'(got), 64'd8);
    i_valid = 1'b0;
    step();

    // Reset with three ops in flight, first one parked on the output.
    for (int k = 1; k <= 3; k++) begin
      i_valid = 1'b1;
      i_a     = 32'(k);
      i_b     = 32'h0;
      i_ready = 1'b1;
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    step();
    chk("rif_pre_valid", 64'(o_valid), 64'd1);
    chk("rif_pre_sum", 64'(o_sum), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rif_valid", 64'(o_valid), 64'd0);
    chk("rif_sum", 64'(o_sum), 64'd0);
    chk("rif_cout", 64'(o_cout), 64'd0);
    chk("rif_ovf", 64'(o_ovf), 64'd0);
    chk("rif_zero", 64'(o_zero), 64'd0);
    chk("rif_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    @(posedge i_clk);
    #3;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    step();
    ghost = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_valid) ghost++;
      step();
    end
    chk("rif_ghost", 64'(ghost), 64'd0);
    run_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor built from the team's 1-bit full-adder cell.
- Splits WIDTH-bit operands into CHUNK-bit slices and adds one slice per pipeline stage, so the carry chain per stage stays short.
- Used as the multi-cycle integer add/sub unit (ALU backend, address and counter arithmetic).
- Valid/ready handshake on both sides; produces sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; 1 <= CHUNK <= WIDTH.
- NSTAGE, WIDTH/CHUNK, derived localparam: number of pipeline stages, equal to the latency in cycles.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  unit can accept an operation this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_cin  in  1  carry-in; ignored when i_sub=1.
- i_sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_sum  out  WIDTH  result.
- o_cout  out  1  carry out of the MSB; in sub mode 1 means no borrow.
- o_ovf  out  1  signed overflow.
- o_zero  out  1  o_sum == 0.

Behaviour:
- Reset:
  - Asynchronous on i_rst high: every stage valid bit, data register and carry register clears to 0.
  - o_valid=0, o_sum=0, o_cout=0, o_ovf=0, o_zero=0.
  - o_ready=1 while in reset and on release.
- Operand conditioning:
  - Effective B = i_sub ? ~i_b : i_b.
  - Effective carry-in = i_sub ? 1 : i_cin.
  - Both are captured at acceptance.
- Pipeline:
  - Stage k (0..NSTAGE-1) adds bits [k*CHUNK +: CHUNK] of A and effective B, plus the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Each stage registers its valid bit, completed low sum bits, still-unprocessed upper operand bits, its carry-out, and the carry into its slice MSB (needed for overflow).
- Advance and handshake:
  - advance = ~o_valid | i_ready.
  - The whole pipeline shifts one stage on advance and holds every register otherwise (global stall).
  - o_ready = advance (combinational).
  - An operation is accepted when i_valid & o_ready.
  - When advance=1 and i_valid=0, a bubble (valid=0) enters stage 0.
- Latency and throughput:
  - A result is presented NSTAGE cycles after acceptance, with no stalls.
  - Throughput is 1 op/cycle while i_ready=1.
  - Results leave in acceptance order, with no loss and no duplication.
- Output:
  - o_sum, o_cout, o_ovf and o_zero are driven from the final stage registers.
  - They stay stable while o_valid=1 and i_ready=0.
  - Values when o_valid=0 are don't-care, except after reset (0).
- Flags:
  - o_cout = carry out of the bit WIDTH-1 slice.
  - o_ovf = carry-into-MSB XOR carry-out-of-MSB.
  - o_zero = ~|o_sum.
- Edge cases:
  - CHUNK=WIDTH gives a single stage with latency 1.
  - CHUNK=1 gives a bit-serial pipeline with latency WIDTH.
- Simultaneous output pop and input accept in the same cycle is allowed when the pipe is full.
- Reset mid-operation discards all in-flight operations; none appear after release.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- Elaboration check: WIDTH % CHUNK != 0 is a fatal error.

Test Plan (WIDTH=32, CHUNK=8, latency 4):
1. Add, cin=0, carry across a slice boundary: A=0x000000FF, B=0x00000001 -> o_valid 4 cycles later; o_sum=0x00000100, o_cout=0, o_ovf=0, o_zero=0.
2. Add, cin=0, full wrap: A=0xFFFFFFFF, B=0x00000001 -> o_sum=0x00000000, o_cout=1, o_zero=1, o_ovf=0.
3. Add, cin=0, signed overflow: A=0x7FFFFFFF, B=0x00000001 -> o_sum=0x80000000, o_ovf=1, o_cout=0.
4. Add, carry-in only: A=0, B=0, cin=1 -> o_sum=0x00000001.
5. Subtract:
   - A=5, B=7, i_sub=1, i_cin=1 -> o_sum=0xFFFFFFFE, o_cout=0, o_ovf=0.
   - A=7, B=5, i_sub=1 -> o_sum=2, o_cout=1.
6. Backpressure:
   - Stimulus: 6 back-to-back ops (A=i, B=0x10, i=1..6), with i_ready low for 3 cycles once the first result appears.
   - Response: o_ready=0 during the stall, o_sum is held, then 0x11..0x16 emerge in order with no gaps once i_ready returns.
   - Full-throughput case: one op/cycle with i_ready always 1 gives o_valid continuously high.
7. Reset in flight:
   - Stimulus: accept 3 ops, assert i_rst asynchronously between clock edges for 2 cycles.
   - Response: o_valid falls immediately without a clock edge, all outputs are 0, and no result emerges in the 6 cycles after release.
   - A new op accepted after release completes normally with latency 4.
